// File: rtl/ara_eoc_monitor.sv
// ara_eoc_monitor: end-of-computation monitor for the simulation harness.
//
// Watches NrChannels tohost exit words and latches the first report of each
// channel. The run ends when every channel has reported, on the first nonzero
// code (StopOnFail), or when the watchdog expires. An optional drain window
// follows before the merged verdict is published.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   exit_i       NrChannels x {code[62:0], valid}; channel c at [c*64 +: 64]
//   exit_o       merged verdict {code, 1'b1} in DONE, 0 otherwise
//   done_o       high in DONE
//   fail_o       high in DONE when the verdict code is nonzero
//   timeout_o    high in DONE when the watchdog ended the run
//   reported_o   sticky per-channel "report latched"
//   fail_chan_o  lowest-index failing channel, meaningful while fail_o is high
//   cycle_cnt_o  RUN cycle count, saturating at all-ones

// Per-channel report latch. Captures the first valid exit word seen while
// run is high and ignores everything after that.
//   clk_i/rst_i  clock and asynchronous active-high reset
//   run          monitor is in RUN
//   exit_word    raw {code, valid} word for this channel
//   reported     report latched (registered)
//   rep_now      reported, including a report arriving this cycle
//   code_now     latched code, or this cycle's code when it is being latched
module ara_eoc_chan (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run,
    input  logic [63:0] exit_word,
    output logic        reported,
    output logic        rep_now,
    output logic [62:0] code_now
);
    logic [62:0] code_q;
    logic        take;

    assign take     = run & exit_word[0] & ~reported;
    assign rep_now  = reported | take;
    assign code_now = take ? exit_word[63:1] : code_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reported <= 1'b0;
            code_q   <= '0;
        end else if (take) begin
            reported <= 1'b1;
            code_q   <= exit_word[63:1];
        end
    end
endmodule

module ara_eoc_monitor #(
    parameter int NrChannels    = 1,
    parameter int TimeoutCycles = 0,
    parameter int DrainCycles   = 0,
    parameter int StopOnFail    = 1,
    localparam int FW = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [64*NrChannels-1:0]  exit_i,
    output logic [63:0]               exit_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic                      timeout_o,
    output logic [NrChannels-1:0]     reported_o,
    output logic [FW-1:0]             fail_chan_o,
    output logic [63:0]               cycle_cnt_o
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    localparam logic [15:0] DRAIN_LOAD = (DrainCycles > 0) ? 16'(DrainCycles - 1) : 16'd0;
    localparam logic [63:0] TMO_LAST   = 64'(TimeoutCycles) - 64'd1;

    state_e                         state_q, state_d;
    logic [15:0]                    drain_q, drain_d;
    logic [63:0]                    cnt_q;
    logic [62:0]                    code_q;
    logic                           tmo_q;
    logic [FW-1:0]                  fch_q;

    logic [NrChannels-1:0]          rep_q, rep_now;
    logic [NrChannels-1:0][62:0]    code_now;
    logic                           run;

    assign run = (state_q == RUN);

    for (genvar c = 0; c < NrChannels; c++) begin : g_chan
        ara_eoc_chan u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .run       (run),
            .exit_word (exit_i[c*64 +: 64]),
            .reported  (rep_q[c]),
            .rep_now   (rep_now[c]),
            .code_now  (code_now[c])
        );
    end

    // Lowest-index channel with a nonzero code, this cycle's reports included.
    logic          found;
    logic [FW-1:0] fidx;
    logic [62:0]   fcode;

    always_comb begin
        found = 1'b0;
        fidx  = '0;
        fcode = '0;
        for (int c = 0; c < NrChannels; c++) begin
            if (!found && rep_now[c] && (code_now[c] != '0)) begin
                found = 1'b1;
                fidx  = FW'(c);
                fcode = code_now[c];
            end
        end
    end

    // Report-driven endings take priority over the watchdog in the same cycle.
    logic rep_end, to_hit, run_end;

    assign rep_end = (&rep_now) | ((StopOnFail != 0) & found);
    assign to_hit  = (TimeoutCycles != 0) && (cnt_q == TMO_LAST);
    assign run_end = rep_end | to_hit;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (run_end) begin
                    if (DrainCycles == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = DONE;
                else               drain_d = drain_q - 16'd1;
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            drain_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            tmo_q   <= 1'b0;
            fch_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (run && (cnt_q != '1)) cnt_q <= cnt_q + 64'd1;
            // Verdict is frozen at the cycle the run ends.
            if (run && run_end) begin
                tmo_q  <= ~rep_end;
                code_q <= rep_end ? fcode : '1;
                fch_q  <= rep_end ? fidx : '0;
            end
        end
    end

    assign done_o      = (state_q == DONE);
    assign exit_o      = done_o ? {code_q, 1'b1} : '0;
    assign fail_o      = done_o & (code_q != '0);
    assign timeout_o   = done_o & tmo_q;
    assign fail_chan_o = fail_o ? fch_q : '0;
    assign reported_o  = rep_q;
    assign cycle_cnt_o = cnt_q;
endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Bench for ara_eoc_monitor: five instances with different parameter sets
// share one clock and reset. Directed report events per phase feed an
// event-level model that derives the end-of-run cycle and verdict, from which
// every per-cycle output is predicted. Literal expectations pin the model.
module tb_ara_eoc_monitor;
    localparam int NI = 5;

    function automatic int cfg_n(int g);
        case (g)
            1, 2:    return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int cfg_t(int g); return (g == 3) ? 20 : 0; endfunction
    function automatic int cfg_d(int g); return (g == 3) ? 3 : (g == 4) ? 5 : 0; endfunction
    function automatic int cfg_s(int g); return (g == 1) ? 0 : 1; endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [255:0] xin    [NI];
    logic [63:0]  d_exit [NI];
    logic [63:0]  d_cnt  [NI];
    logic         d_done [NI];
    logic         d_fail [NI];
    logic         d_tmo  [NI];
    logic [3:0]   d_rep  [NI];
    logic [1:0]   d_fch  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N  = cfg_n(g);
        localparam int FW = (N > 1) ? $clog2(N) : 1;
        logic [N-1:0]  rep;
        logic [FW-1:0] fch;
        logic [63:0]   ex, cnt;
        logic          dn, fl, to;

        ara_eoc_monitor #(
            .NrChannels    (N),
            .TimeoutCycles (cfg_t(g)),
            .DrainCycles   (cfg_d(g)),
            .StopOnFail    (cfg_s(g))
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .exit_i      (xin[g][N*64-1:0]),
            .exit_o      (ex),
            .done_o      (dn),
            .fail_o      (fl),
            .timeout_o   (to),
            .reported_o  (rep),
            .fail_chan_o (fch),
            .cycle_cnt_o (cnt)
        );

        assign d_exit[g] = ex;
        assign d_cnt[g]  = cnt;
        assign d_done[g] = dn;
        assign d_fail[g] = fl;
        assign d_tmo[g]  = to;
        assign d_rep[g]  = 4'(rep);
        assign d_fch[g]  = 2'(fch);
    end

    typedef struct {
        int          g;
        int          cyc;
        int          ch;
        logic [62:0] code;
    } ev_t;

    ev_t evq[$];

    // Model state, per instance
    int          fc    [NI][4];
    logic [62:0] fcode [NI][4];
    int          e_end [NI];
    bit          m_tmo [NI];
    logic [62:0] vcode [NI];
    int          vch   [NI];
    int          rise  [NI];

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic add(int g, int cyc, int ch, logic [62:0] code);
        ev_t e;
        e.g = g; e.cyc = cyc; e.ch = ch; e.code = code;
        evq.push_back(e);
    endtask

    // First report per channel, then the earliest cycle at which any ending
    // condition holds, then the verdict from the channels reported by then.
    task automatic model_prep();
        for (int g = 0; g < NI; g++) begin
            for (int c = 0; c < 4; c++) begin fc[g][c] = -1; fcode[g][c] = '0; end
            foreach (evq[i])
                if (evq[i].g == g && fc[g][evq[i].ch] < 0) begin
                    fc[g][evq[i].ch]    = evq[i].cyc;
                    fcode[g][evq[i].ch] = evq[i].code;
                end
            e_end[g] = -1; m_tmo[g] = 1'b0; vcode[g] = '0; vch[g] = 0; rise[g] = -1;
            for (int k = 0; k < 200 && e_end[g] < 0; k++) begin
                bit all_r = 1'b1, any_f = 1'b0;
                for (int c = 0; c < cfg_n(g); c++) begin
                    if (fc[g][c] >= 0 && fc[g][c] <= k) begin
                        if (fcode[g][c] != '0) any_f = 1'b1;
                    end else all_r = 1'b0;
                end
                if (all_r || (cfg_s(g) != 0 && any_f)) e_end[g] = k;
                else if (cfg_t(g) != 0 && k == cfg_t(g) - 1) begin
                    e_end[g] = k; m_tmo[g] = 1'b1;
                end
            end
            if (m_tmo[g]) vcode[g] = '1;
            else if (e_end[g] >= 0)
                for (int c = cfg_n(g) - 1; c >= 0; c--)
                    if (fc[g][c] >= 0 && fc[g][c] <= e_end[g] && fcode[g][c] != '0) begin
                        vcode[g] = fcode[g][c]; vch[g] = c;
                    end
        end
    endtask

    task automatic check_inst(int g, int k);
        int         eff;
        logic [3:0] m;
        bit         dn;
        string      p;
        p   = $sformatf("g%0d k%0d", g, k);
        eff = (e_end[g] < 0 || k < e_end[g]) ? k : e_end[g];
        m   = '0;
        for (int c = 0; c < cfg_n(g); c++)
            if (fc[g][c] >= 0 && fc[g][c] <= eff) m[c] = 1'b1;
        dn = (e_end[g] >= 0) && (k >= e_end[g] + cfg_d(g));
        if (dn && rise[g] < 0 && d_done[g]) rise[g] = k;
        chk({p, " reported"}, 64'(d_rep[g]), 64'(m));
        chk({p, " cycle_cnt"}, d_cnt[g], 64'(eff + 1));
        chk({p, " done"}, 64'(d_done[g]), 64'(dn));
        chk({p, " exit"}, d_exit[g], dn ? {vcode[g], 1'b1} : 64'd0);
        chk({p, " fail"}, 64'(d_fail[g]), 64'(dn && vcode[g] != '0));
        chk({p, " timeout"}, 64'(d_tmo[g]), 64'(dn && m_tmo[g]));
        if (dn && vcode[g] != '0 && !m_tmo[g])
            chk({p, " fail_chan"}, 64'(d_fch[g]), 64'(vch[g]));
    endtask

    task automatic reset_check(string tag);
        rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            string p;
            p = $sformatf("%s g%0d", tag, g);
            chk({p, " exit"}, d_exit[g], 64'd0);
            chk({p, " done"}, 64'(d_done[g]), 64'd0);
            chk({p, " fail"}, 64'(d_fail[g]), 64'd0);
            chk({p, " timeout"}, 64'(d_tmo[g]), 64'd0);
            chk({p, " reported"}, 64'(d_rep[g]), 64'd0);
            chk({p, " fail_chan"}, 64'(d_fch[g]), 64'd0);
            chk({p, " cycle_cnt"}, d_cnt[g], 64'd0);
        end
    endtask

    // Called at a negedge with reset just released; edge k is the k-th
    // rising edge from there, outputs sampled on the following negedge.
    task automatic run_phase(int len);
        model_prep();
        for (int k = 0; k < len; k++) begin
            for (int g = 0; g < NI; g++) xin[g] = '0;
            foreach (evq[i])
                if (evq[i].cyc == k) xin[evq[i].g][evq[i].ch*64 +: 64] = {evq[i].code, 1'b1};
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < NI; g++) check_inst(g, k);
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) xin[g] = '0;
        #3;
        reset_check("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Phase 1: the main scenarios
        evq.delete();
        add(0, 10, 0, 63'd0);
        add(1, 3, 0, 63'd0); add(1, 3, 1, 63'd5); add(1, 7, 2, 63'd0); add(1, 9, 3, 63'd3);
        add(2, 4, 2, 63'd7);
        add(4, 6, 0, 63'd0); add(4, 8, 0, 63'd9);
        run_phase(30);
        chk("p1 g0 exit", d_exit[0], 64'h1);
        chk("p1 g0 rise", 64'(rise[0]), 64'd10);
        chk("p1 g1 exit", d_exit[1], 64'hB);
        chk("p1 g1 fail_chan", 64'(d_fch[1]), 64'd1);
        chk("p1 g1 reported", 64'(d_rep[1]), 64'hF);
        chk("p1 g1 rise", 64'(rise[1]), 64'd9);
        chk("p1 g2 exit", d_exit[2], 64'hF);
        chk("p1 g2 fail_chan", 64'(d_fch[2]), 64'd2);
        chk("p1 g2 reported", 64'(d_rep[2]), 64'h4);
        chk("p1 g2 rise", 64'(rise[2]), 64'd4);
        chk("p1 g3 exit", d_exit[3], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("p1 g3 timeout", 64'(d_tmo[3]), 64'd1);
        chk("p1 g3 cycle_cnt", d_cnt[3], 64'd20);
        chk("p1 g3 rise", 64'(rise[3]), 64'd22);
        chk("p1 g4 exit", d_exit[4], 64'h1);
        chk("p1 g4 rise", 64'(rise[4]), 64'd11);
        #2;
        reset_check("rst_in_done");
        @(negedge clk);
        rst = 1'b0;

        // Phase 2: last report on the watchdog cycle, simultaneous failures,
        // and instance 4 left in DRAIN for the reset
        evq.delete();
        add(0, 2, 0, 63'd4);
        add(2, 5, 1, 63'd2); add(2, 5, 3, 63'd6);
        add(3, 5, 0, 63'd0); add(3, 19, 1, 63'd0);
        add(4, 20, 0, 63'd0);
        run_phase(24);
        chk("p2 g0 exit", d_exit[0], 64'h9);
        chk("p2 g2 exit", d_exit[2], 64'h5);
        chk("p2 g2 fail_chan", 64'(d_fch[2]), 64'd1);
        chk("p2 g3 exit", d_exit[3], 64'h1);
        chk("p2 g3 timeout", 64'(d_tmo[3]), 64'd0);
        chk("p2 g3 rise", 64'(rise[3]), 64'd22);
        chk("p2 g4 in drain", 64'(d_done[4]), 64'd0);
        #2;
        reset_check("rst_in_drain");
        @(negedge clk);
        rst = 1'b0;

        // Phase 3: fresh runs after the mid-drain reset
        evq.delete();
        add(1, 0, 0, 63'd0); add(1, 0, 1, 63'd0); add(1, 0, 2, 63'd0); add(1, 0, 3, 63'd0);
        add(3, 2, 1, 63'd5);
        add(4, 1, 0, 63'd0);
        run_phase(12);
        chk("p3 g1 exit", d_exit[1], 64'h1);
        chk("p3 g1 rise", 64'(rise[1]), 64'd0);
        chk("p3 g3 exit", d_exit[3], 64'hB);
        chk("p3 g3 rise", 64'(rise[3]), 64'd5);
        chk("p3 g4 exit", d_exit[4], 64'h1);
        chk("p3 g4 rise", 64'(rise[4]), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
